conv2d_mac_sched: RTL and testbench

- Sequencer for the FP32 2D-convolution datapath (external IEEE-754 single-precision MULTIPLIER and ADDER).
- Walks every valid output position of an N×N image with an M×M kernel. For each tap it reads the image and kernel buffers, feeds the multiplier, and accumulates through the adder.
- Emits one FP32 result per output position over a valid/ready stream, in row-major order.
- Sits between the operand buffers and the result FIFO, and owns all loop counters.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_addr_gen.sv | 79 +++++++
 rtl/conv2d_mac_sched.sv | 177 +++++++++++++++++
 tb/tb_conv2d_mac_sched.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and helpers for the FP32 convolution sequencer.
// Build option: CONV_ZERO_SKIP_EN (see conv2d_mac_sched.sv).
package conv_pkg;

    localparam int              FP_W    = 32;
    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        OPER  = 3'd2,
        MUL   = 3'd3,
        ADD   = 3'd4,
        EMIT  = 3'd5,
        DONE  = 3'd6
    } state_e;

    // True for +0.0 and -0.0 (sign bit ignored).
    function automatic logic is_fp_zero(input logic [FP_W-1:0] v);
        return v[FP_W-2:0] == '0;
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Loop counters for the convolution walk: c3/c4 select the output position,
// c5/c6 select the kernel tap. Produces image/kernel buffer addresses and
// end-of-loop flags for the sequencer.
module conv_addr_gen #(
    parameter int N   = 3,
    parameter int M   = 2,
    parameter int IAW = 4,
    parameter int KAW = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           clear,
    input  logic           advance_tap,
    input  logic           advance_pos,
    output logic [IAW-1:0] img_addr,
    output logic [KAW-1:0] krn_addr,
    output logic           last_tap,
    output logic           last_pos
);

    localparam int CW = $clog2(N + 1);

    logic [CW-1:0] c3_q, c4_q, c5_q, c6_q;
    logic [CW-1:0] c3_d, c4_d, c5_d, c6_d;

    assign last_tap = (c5_q == CW'(M - 1)) && (c6_q == CW'(M - 1));
    assign last_pos = (c3_q == CW'(N - M)) && (c4_q == CW'(N - M));

    assign img_addr = IAW'((int'(c3_q) + int'(c5_q)) * N + int'(c4_q) + int'(c6_q));
    assign krn_addr = KAW'(int'(c5_q) * M + int'(c6_q));

    // Next counter values: tap column wraps into tap row (and the tap pair
    // returns to 0 after the last tap); output column wraps into output row.
    always_comb begin
        c3_d = c3_q;
        c4_d = c4_q;
        c5_d = c5_q;
        c6_d = c6_q;
        if (clear) begin
            c3_d = '0;
            c4_d = '0;
            c5_d = '0;
            c6_d = '0;
        end else begin
            if (advance_tap) begin
                if (c6_q == CW'(M - 1)) begin
                    c6_d = '0;
                    c5_d = (c5_q == CW'(M - 1)) ? '0 : c5_q + CW'(1);
                end else begin
                    c6_d = c6_q + CW'(1);
                end
            end
            if (advance_pos) begin
                if (c4_q == CW'(N - M)) begin
                    c4_d = '0;
                    c3_d = (c3_q == CW'(N - M)) ? '0 : c3_q + CW'(1);
                end else begin
                    c4_d = c4_q + CW'(1);
                end
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c3_q <= '0;
            c4_q <= '0;
            c5_q <= '0;
            c6_q <= '0;
        end else begin
            c3_q <= c3_d;
            c4_q <= c4_d;
            c5_q <= c5_d;
            c6_q <= c6_d;
        end
    end

endmodule

// File: rtl/conv2d_mac_sched.sv
// FP32 2D-convolution sequencer: walks every valid output position, feeds
// the external multiplier/adder one tap at a time and streams one result per
// position over valid/ready. Optional build macro CONV_ZERO_SKIP_EN lets a
// zero kernel tap bypass MUL/ADD.
module conv2d_mac_sched
    import conv_pkg::*;
#(
    parameter int   N       = 3,
    parameter int   M       = 2,
    parameter int   MUL_LAT = 1,
    parameter int   ADD_LAT = 1,
    localparam int  IAW     = $clog2(N * N),
    localparam int  KAW     = (M > 1) ? $clog2(M * M) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic [IAW-1:0]  img_addr,
    output logic [KAW-1:0]  krn_addr,
    output logic            rd_en,
    input  logic [FP_W-1:0] img_data,
    input  logic [FP_W-1:0] krn_data,
    output logic [FP_W-1:0] mul_a,
    output logic [FP_W-1:0] mul_b,
    input  logic [FP_W-1:0] mul_p,
    output logic [FP_W-1:0] add_a,
    output logic [FP_W-1:0] add_b,
    input  logic [FP_W-1:0] add_y,
    output logic [FP_W-1:0] out_data,
    output logic            out_valid,
    input  logic            out_ready
);

    if (N < M) begin : g_bad_size
        $error("conv2d_mac_sched: N must be >= M");
    end

    state_e          state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [FP_W-1:0] acc_q, acc_d, prod_q, prod_d;
    logic [FP_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [FP_W-1:0] out_data_q, out_data_d;
    logic            out_valid_q, out_valid_d, busy_q, busy_d, done_q, done_d;
    logic            clear, adv_tap, adv_pos, last_tap, last_pos;

    conv_addr_gen #(.N(N), .M(M), .IAW(IAW), .KAW(KAW)) u_addr (
        .clk(clk), .rst(rst), .clear(clear), .advance_tap(adv_tap),
        .advance_pos(adv_pos), .img_addr(img_addr), .krn_addr(krn_addr),
        .last_tap(last_tap), .last_pos(last_pos)
    );

    assign rd_en     = (state_q == FETCH);
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign add_a     = acc_q;
    assign add_b     = prod_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

    // Sequencer next-state and datapath-register updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        clear       = 1'b0;
        adv_tap     = 1'b0;
        adv_pos     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    clear   = 1'b1;
                    acc_d   = FP_ZERO;
                    busy_d  = 1'b1;
                end
            end
            FETCH: state_d = OPER;
            OPER: begin
`ifdef CONV_ZERO_SKIP_EN
                if (is_fp_zero(krn_data)) begin
                    // Zero tap contributes nothing; NaN/Inf pixels are not propagated.
                    adv_tap = 1'b1;
                    state_d = last_tap ? EMIT : FETCH;
                end else begin
                    mul_a_d = img_data;
                    mul_b_d = krn_data;
                    cnt_d   = '0;
                    state_d = MUL;
                end
`else
                mul_a_d = img_data;
                mul_b_d = krn_data;
                cnt_d   = '0;
                state_d = MUL;
`endif
            end
            MUL: begin
                if (cnt_q == 8'(MUL_LAT - 1)) begin
                    prod_d  = mul_p;
                    cnt_d   = '0;
                    state_d = ADD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ADD: begin
                if (cnt_q == 8'(ADD_LAT - 1)) begin
                    acc_d   = add_y;
                    adv_tap = 1'b1;
                    state_d = last_tap ? EMIT : FETCH;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            EMIT: begin
                // First EMIT cycle loads the output register; afterwards it
                // holds until the sink takes it.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = FP_ZERO;
                    adv_pos     = 1'b1;
                    if (last_pos) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= FP_ZERO;
            prod_q      <= FP_ZERO;
            mul_a_q     <= FP_ZERO;
            mul_b_q     <= FP_ZERO;
            out_data_q  <= FP_ZERO;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_conv2d_mac_sched.sv
// Bench for conv2d_mac_sched: dut0 uses unit latencies, dut1 uses
// MUL_LAT=3/ADD_LAT=2. Buffers and FP units are modelled behaviourally for
// small non-negative integer values.
module tb_conv2d_mac_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        start0 = 1'b0, start1 = 1'b0, out_ready = 1'b1;
    logic [31:0] img_mem [9];
    logic [31:0] krn_mem [4];
    logic [31:0] exp_q [$];
    int          n_pass = 0, n_total = 0;

    logic        busy0, done0, rd_en0, out_valid0;
    logic [3:0]  img_addr0;
    logic [1:0]  krn_addr0;
    logic [31:0] img_data0 = '0, krn_data0 = '0;
    logic [31:0] mul_a0, mul_b0, mul_p0, add_a0, add_b0, add_y0, out_data0;
    logic        busy1, done1, rd_en1, out_valid1;
    logic [3:0]  img_addr1;
    logic [1:0]  krn_addr1;
    logic [31:0] img_data1 = '0, krn_data1 = '0;
    logic [31:0] mul_a1, mul_b1, mul_p1, add_a1, add_b1, add_y1, out_data1;

    function automatic int fp2int(input logic [31:0] b);
        int e;
        logic [31:0] m;
        if (b[30:0] == 31'd0) return 0;
        e = int'(b[30:23]) - 127;
        m = {8'd0, 1'b1, b[22:0]};
        if (e < 0 || e > 23) return 0;
        return int'(m >> (23 - e));
    endfunction

    function automatic logic [31:0] int2fp(input int v);
        int p;
        logic [31:0] u, mant;
        if (v <= 0) return 32'h0;
        u = v;
        p = 0;
        for (int i = 0; i < 32; i++) if (u[i]) p = i;
        mant = u << (23 - p);
        return {1'b0, 8'(p + 127), mant[22:0]};
    endfunction

    assign mul_p0 = int2fp(fp2int(mul_a0) * fp2int(mul_b0));
    assign add_y0 = int2fp(fp2int(add_a0) + fp2int(add_b0));
    assign mul_p1 = int2fp(fp2int(mul_a1) * fp2int(mul_b1));
    assign add_y1 = int2fp(fp2int(add_a1) + fp2int(add_b1));

    always @(posedge clk) begin
        if (rd_en0) begin
            img_data0 <= img_mem[img_addr0];
            krn_data0 <= krn_mem[krn_addr0];
        end
        if (rd_en1) begin
            img_data1 <= img_mem[img_addr1];
            krn_data1 <= krn_mem[krn_addr1];
        end
    end

    conv2d_mac_sched #(.N(3), .M(2), .MUL_LAT(1), .ADD_LAT(1)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .img_addr(img_addr0), .krn_addr(krn_addr0), .rd_en(rd_en0),
        .img_data(img_data0), .krn_data(krn_data0), .mul_a(mul_a0), .mul_b(mul_b0),
        .mul_p(mul_p0), .add_a(add_a0), .add_b(add_b0), .add_y(add_y0),
        .out_data(out_data0), .out_valid(out_valid0), .out_ready(out_ready)
    );

    conv2d_mac_sched #(.N(3), .M(2), .MUL_LAT(3), .ADD_LAT(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
        .img_addr(img_addr1), .krn_addr(krn_addr1), .rd_en(rd_en1),
        .img_data(img_data1), .krn_data(krn_data1), .mul_a(mul_a1), .mul_b(mul_b1),
        .mul_p(mul_p1), .add_a(add_a1), .add_b(add_b1), .add_y(add_y1),
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready)
    );

    // Reference convolution of the current buffers, queued in row-major order.
    task automatic push_model();
        int s;
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 2; c++) begin
                s = 0;
                for (int i = 0; i < 2; i++)
                    for (int j = 0; j < 2; j++)
                        s += fp2int(img_mem[(r + i) * 3 + c + j]) * fp2int(krn_mem[i * 2 + j]);
                exp_q.push_back(int2fp(s));
            end
    endtask

    task automatic push_uniform_literals();
        exp_q.push_back(32'h4140_0000);
        exp_q.push_back(32'h4180_0000);
        exp_q.push_back(32'h41C0_0000);
        exp_q.push_back(32'h41E0_0000);
    endtask

    task automatic set_kernel(input logic [31:0] k0, k1, k2, k3);
        krn_mem[0] = k0; krn_mem[1] = k1; krn_mem[2] = k2; krn_mem[3] = k3;
    endtask

    task automatic pulse_start0();
        @(negedge clk) start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        n_total++;
        if ({out_valid0, busy0, done0, rd_en0} !== 4'b0) $display("FAIL reset_ctrl got %b want 0000", {out_valid0, busy0, done0, rd_en0});
        else n_pass++;
        n_total++;
        if ({img_addr0, krn_addr0} !== 6'd0) $display("FAIL reset_addr got %h want 0", {img_addr0, krn_addr0});
        else n_pass++;
        n_total++;
        if ({mul_a0, mul_b0, out_data0} !== 96'd0) $display("FAIL reset_data got %h want 0", {mul_a0, mul_b0, out_data0});
        else n_pass++;
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_uniform();
        int cyc;
        logic [31:0] e;
        set_kernel(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        exp_q.delete();
        push_uniform_literals();
        out_ready = 1'b1;
        pulse_start0();
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (out_valid0 !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
            n_total++;
            if (cyc !== 17) $display("FAIL uniform_latency[%0d] got %0d want 17", k, cyc);
            else n_pass++;
            e = exp_q.pop_front();
            n_total++;
            if (out_data0 !== e) $display("FAIL uniform_data[%0d] got %h want %h", k, out_data0, e);
            else n_pass++;
            if (k == 0) begin
                n_total++;
                if (busy0 !== 1'b1) $display("FAIL uniform_busy got %b want 1", busy0);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        n_total++;
        if ({done0, busy0} !== 2'b10) $display("FAIL uniform_done got %b want 10", {done0, busy0});
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (done0 !== 1'b0) $display("FAIL uniform_done_pulse got %b want 0", done0);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [31:0] e;
        logic held_ok;
        exp_q.delete();
        push_model();
        out_ready = 1'b0;
        pulse_start0();
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (out_valid0 !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
            e = exp_q.pop_front();
            n_total++;
            if (out_data0 !== e) $display("FAIL bp_data[%0d] got %h want %h", k, out_data0, e);
            else n_pass++;
            if (k == 0) begin
                held_ok = 1'b1;
                repeat (5) begin
                    @(posedge clk); #1;
                    if (out_data0 !== e || rd_en0 !== 1'b0 || out_valid0 !== 1'b1) held_ok = 1'b0;
                end
                n_total++;
                if (held_ok !== 1'b1) $display("FAIL bp_hold got data=%h rd_en=%b valid=%b want %h/0/1", out_data0, rd_en0, out_valid0, e);
                else n_pass++;
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        n_total++;
        if (done0 !== 1'b1) $display("FAIL bp_done got %b want 1", done0);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [31:0] e;
        exp_q.delete();
        push_model();
        out_ready = 1'b1;
        pulse_start0();
        repeat (6) @(posedge clk);
        #1;
        n_total++;
        if ({mul_a0, mul_b0} !== {32'h4000_0000, 32'h3F80_0000}) $display("FAIL midrst_operands got %h want 400000003f800000", {mul_a0, mul_b0});
        else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if ({out_valid0, busy0, done0, rd_en0, img_addr0, krn_addr0} !== 10'd0) $display("FAIL midrst_ctrl got %h want 0", {out_valid0, busy0, done0, rd_en0, img_addr0, krn_addr0});
        else n_pass++;
        n_total++;
        if ({mul_a0, mul_b0, add_a0, add_b0, out_data0} !== 160'd0) $display("FAIL midrst_data got %h want 0", {mul_a0, mul_b0, add_a0, add_b0, out_data0});
        else n_pass++;
        @(negedge clk) rst = 1'b1;
        pulse_start0();
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (out_valid0 !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
            e = exp_q.pop_front();
            n_total++;
            if (out_data0 !== e || cyc !== 17) $display("FAIL midrst_rerun[%0d] got %h@%0d want %h@17", k, out_data0, cyc, e);
            else n_pass++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_start_busy();
        int cyc;
        logic [31:0] e;
        exp_q.delete();
        push_model();
        out_ready = 1'b1;
        pulse_start0();
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (out_valid0 !== 1'b1 && cyc < 200) begin
                start0 = (cyc == 3);
                @(posedge clk); #1; cyc++;
            end
            start0 = 1'b0;
            e = exp_q.pop_front();
            n_total++;
            if (out_data0 !== e || cyc !== 17) $display("FAIL startbusy[%0d] got %h@%0d want %h@17", k, out_data0, cyc, e);
            else n_pass++;
            if (k < 3) start0 = 1'b1;
            @(posedge clk); #1;
            start0 = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({busy0, out_valid0} !== 2'b00) $display("FAIL startbusy_idle got %b want 00", {busy0, out_valid0});
        else n_pass++;
    endtask

    task automatic test_zero_skip();
        int cyc;
        logic [31:0] e;
        set_kernel(32'h3F80_0000, 32'h0, 32'h0, 32'h3F80_0000);
        exp_q.delete();
        exp_q.push_back(32'h40C0_0000);
        exp_q.push_back(32'h4100_0000);
        exp_q.push_back(32'h4140_0000);
        exp_q.push_back(32'h4160_0000);
        out_ready = 1'b1;
        pulse_start0();
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (out_valid0 !== 1'b1 && cyc < 200) begin @(posedge clk); #1; cyc++; end
            e = exp_q.pop_front();
            n_total++;
            if (out_data0 !== e) $display("FAIL zskip_data[%0d] got %h want %h", k, out_data0, e);
            else n_pass++;
`ifndef CONV_ZERO_SKIP_EN
            n_total++;
            if (cyc !== 17) $display("FAIL zskip_latency[%0d] got %0d want 17", k, cyc);
            else n_pass++;
`endif
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_slow();
        int cyc;
        logic [31:0] e;
        set_kernel(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        exp_q.delete();
        push_uniform_literals();
        out_ready = 1'b1;
        @(negedge clk) start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc = 0;
            while (out_valid1 !== 1'b1 && cyc < 300) begin @(posedge clk); #1; cyc++; end
            e = exp_q.pop_front();
            n_total++;
            if (out_data1 !== e || cyc !== 29) $display("FAIL slow[%0d] got %h@%0d want %h@29", k, out_data1, cyc, e);
            else n_pass++;
            @(posedge clk); #1;
        end
        n_total++;
        if (done1 !== 1'b1) $display("FAIL slow_done got %b want 1", done1);
        else n_pass++;
    endtask

    initial begin
        for (int i = 0; i < 9; i++) img_mem[i] = int2fp(i + 1);
        set_kernel(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        test_reset();
        test_uniform();
        test_backpressure();
        test_reset_mid();
        test_start_busy();
        test_zero_skip();
        test_slow();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
